// File: rtl/hdbus_arb_if.sv
// Register-bus (hdbus) signal bundle between the arbiter and the register target.
// The arbiter drives request/address/data; the target returns ack/err/read data.
interface hdbus_arb_if;
  logic [7:0] hdaddr;
  logic [7:0] hdwrdata;
  logic       hdreq;
  logic       hdwr;
  logic       hdlast;
  logic [7:0] hdrddata;
  logic       hdack;
  logic       hderr;

  modport master (
    output hdaddr, hdwrdata, hdreq, hdwr, hdlast,
    input  hdrddata, hdack, hderr
  );

  modport slave (
    input  hdaddr, hdwrdata, hdreq, hdwr, hdlast,
    output hdrddata, hdack, hderr
  );
endinterface

// File: rtl/hdbus_arb.sv
// Three-requester round-robin arbiter for the hdbus register bus.
// An owner keeps the bus through a locked sequence (rqlast=0) and loses it on
// the last access, a bus error, abandoning its request, or a response timeout.
// Every ownership ends with at least one idle cycle so hdreq drops between owners.
module hdbus_arb #(
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [23:0] rqaddr,
  input  logic [23:0] rqwrdata,
  input  logic [2:0]  rqreq,
  input  logic [2:0]  rqwr,
  input  logic [2:0]  rqlast,
  output logic [2:0]  rqack,
  output logic [2:0]  rqerr,
  output logic [7:0]  rqrddata,
  output logic [1:0]  grant,
  output logic        busy,
  hdbus_arb_if.master hd
);

  // Wide enough to hold TIMEOUT-1 plus one spare bit, so it can never wrap.
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWN   = 2'd1;
  localparam logic [1:0] S_ABORT = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [1:0]    grant_nxt;
  logic [1:0]    ptr, ptr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    cand1, cand2, pick;

  // Successor of a requester index, modulo 3.
  function automatic logic [1:0] next3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Round-robin pick: the requester after the last owner has highest priority,
  // the last owner itself the lowest.
  always_comb begin
    cand1 = next3(ptr);
    cand2 = next3(cand1);
    if (rqreq[cand1])      pick = cand1;
    else if (rqreq[cand2]) pick = cand2;
    else                   pick = ptr;
  end

  // Next-state, bus multiplexing and per-requester response steering.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_nxt      = state;
    grant_nxt      = grant;
    ptr_nxt        = ptr;
    cnt_nxt        = cnt;
    rqack          = '0;
    rqerr          = '0;
    hd.hdreq       = 1'b0;
    hd.hdwr        = 1'b0;
    hd.hdlast      = 1'b1;
    hd.hdaddr      = '0;
    hd.hdwrdata    = '0;

    case (state)
      S_IDLE: begin
        if (|rqreq) begin
          state_nxt = S_OWN;
          grant_nxt = pick;
          cnt_nxt   = '0;
        end
      end

      S_OWN: begin
        hd.hdreq    = rqreq[grant];
        hd.hdwr     = rqwr[grant];
        hd.hdlast   = rqlast[grant];
        hd.hdaddr   = rqaddr[{grant, 3'b000} +: 8];
        hd.hdwrdata = rqwrdata[{grant, 3'b000} +: 8];

        if (hd.hdack) begin
          rqack[grant] = ~hd.hderr;
          rqerr[grant] = hd.hderr;
          cnt_nxt      = '0;
          // A bus error always breaks a locked sequence.
          if (rqlast[grant] || hd.hderr) begin
            state_nxt = S_IDLE;
            ptr_nxt   = grant;
          end
        end else if (!rqreq[grant]) begin
          // Owner withdrew mid-sequence: release without reporting anything.
          state_nxt = S_IDLE;
          ptr_nxt   = grant;
        end else if (cnt == CNT_LIMIT) begin
          rqerr[grant] = 1'b1;
          state_nxt    = S_ABORT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      S_ABORT: begin
        state_nxt = S_IDLE;
        ptr_nxt   = grant;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign rqrddata = hd.hdrddata;
  assign busy     = (state == S_OWN);

  // State registers; reset leaves requester 0 as the first winner (pointer=2).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      grant <= 2'd0;
      ptr   <= 2'd2;
      cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state <= state_nxt;
      grant <= grant_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_hdbus_arb.sv
// Directed bench for hdbus_arb (TIMEOUT=16). Stimulus tasks push the expected
// requester response into a scoreboard; a monitor pops and compares whenever
// the DUT raises any rqack/rqerr.
module tb_hdbus_arb;

  logic        clk = 1'b0;
  logic        rstn;
  logic [23:0] rqaddr, rqwrdata;
  logic [2:0]  rqreq, rqwr, rqlast;
  logic [2:0]  rqack, rqerr;
  logic [7:0]  rqrddata;
  logic [1:0]  grant;
  logic        busy;

  hdbus_arb_if hd();

  hdbus_arb #(.TIMEOUT(16)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rqaddr   (rqaddr),
    .rqwrdata (rqwrdata),
    .rqreq    (rqreq),
    .rqwr     (rqwr),
    .rqlast   (rqlast),
    .rqack    (rqack),
    .rqerr    (rqerr),
    .rqrddata (rqrddata),
    .grant    (grant),
    .busy     (busy),
    .hd       (hd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ack;
    logic [2:0] err;
    logic [7:0] rd;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: any requester response must match the oldest expectation.
  always @(negedge clk) begin
    if (rstn === 1'b1 && (rqack !== 3'b000 || rqerr !== 3'b000)) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'({rqerr, rqack}), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rqack", 32'(rqack), 32'(e.ack));
        check("rqerr", 32'(rqerr), 32'(e.err));
        if (e.ack != 3'b000) check("rqrddata", 32'(rqrddata), 32'(e.rd));
      end
    end
  end

  // Wait for ownership, check the bus mux, then ack once and release requests in drop.
  task automatic ack_access(input logic [1:0] g, input logic [7:0] exp_addr,
                            input logic [7:0] exp_wdata, input logic exp_wr,
                            input logic err, input logic [7:0] rd,
                            input logic [2:0] drop, output int waited);
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (!busy && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("own_reached", 32'(busy), 32'd1);
    check("grant", 32'(grant), 32'(g));
    check("hdreq", 32'(hd.hdreq), 32'd1);
    check("hdaddr", 32'(hd.hdaddr), 32'(exp_addr));
    check("hdwrdata", 32'(hd.hdwrdata), 32'(exp_wdata));
    check("hdwr", 32'(hd.hdwr), 32'(exp_wr));
    e.ack = err ? 3'b000 : (3'b001 << g);
    e.err = err ? (3'b001 << g) : 3'b000;
    e.rd  = rd;
    sb.push_back(e);
    @(posedge clk); #1;
    hd.hdack    = 1'b1;
    hd.hderr    = err;
    hd.hdrddata = rd;
    @(posedge clk); #1;
    hd.hdack = 1'b0;
    hd.hderr = 1'b0;
    rqreq    = rqreq & ~drop;
  endtask

  task automatic expect_idle(input string name);
    @(negedge clk);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_hdreq"}, 32'(hd.hdreq), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    int cyc;
    exp_t e;

    rstn        = 1'b0;
    rqaddr      = {8'h12, 8'h11, 8'h10};
    rqwrdata    = {8'h33, 8'h22, 8'h11};
    rqreq       = 3'b000;
    rqwr        = 3'b000;
    rqlast      = 3'b111;
    hd.hdack    = 1'b0;
    hd.hderr    = 1'b0;
    hd.hdrddata = 8'h00;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_hdreq", 32'(hd.hdreq), 32'd0);
    check("rst_hdlast", 32'(hd.hdlast), 32'd1);
    check("rst_hdaddr", 32'(hd.hdaddr), 32'd0);
    check("rst_hdwr", 32'(hd.hdwr), 32'd0);
    check("rst_rqack", 32'(rqack), 32'd0);

    // All three request: grants 0,1,2,0, one idle cycle between owners
    @(negedge clk);
    rstn  = 1'b1;
    rqreq = 3'b111;
    ack_access(2'd0, 8'h10, 8'h11, 1'b0, 1'b0, 8'hA0, 3'b000, w);
    expect_idle("rr0");
    ack_access(2'd1, 8'h11, 8'h22, 1'b0, 1'b0, 8'hA1, 3'b000, w);
    check("rr1_gap", 32'(w), 32'd0);
    expect_idle("rr1");
    ack_access(2'd2, 8'h12, 8'h33, 1'b0, 1'b0, 8'hA2, 3'b000, w);
    check("rr2_gap", 32'(w), 32'd0);
    expect_idle("rr2");
    ack_access(2'd0, 8'h10, 8'h11, 1'b0, 1'b0, 8'hA3, 3'b111, w);
    check("rr3_gap", 32'(w), 32'd0);
    expect_idle("rr3");

    // Requester 1 reads 0x42, target returns 0x40
    rqaddr = {8'h12, 8'h42, 8'h10};
    rqreq  = 3'b010;
    ack_access(2'd1, 8'h42, 8'h22, 1'b0, 1'b0, 8'h40, 3'b010, w);
    expect_idle("rd42");

    // Requester 0 locked 12-write sequence while requester 2 waits
    rqlast = 3'b110;
    rqwr   = 3'b001;
    rqreq  = 3'b001;
    for (int i = 0; i < 12; i++) begin
      rqaddr[7:0]   = 8'h20 + 8'(i);
      rqwrdata[7:0] = 8'hA0 + 8'(i);
      if (i == 11) rqlast[0] = 1'b1;
      ack_access(2'd0, 8'h20 + 8'(i), 8'hA0 + 8'(i), 1'b1, 1'b0, 8'h00,
                 (i == 11) ? 3'b001 : 3'b000, w);
      if (i > 0) check("lock_contig", 32'(w), 32'd0);
      if (i == 0) rqreq[2] = 1'b1;
    end
    expect_idle("lock_end");
    ack_access(2'd2, 8'h12, 8'h33, 1'b0, 1'b0, 8'h5C, 3'b100, w);
    check("after_lock_gap", 32'(w), 32'd0);
    expect_idle("after_lock");

    // Bus error mid-sequence ends ownership despite rqlast=0
    rqwr   = 3'b000;
    rqlast = 3'b101;
    rqreq  = 3'b010;
    ack_access(2'd1, 8'h42, 8'h22, 1'b0, 1'b0, 8'h61, 3'b000, w);
    ack_access(2'd1, 8'h42, 8'h22, 1'b0, 1'b1, 8'h62, 3'b010, w);
    check("err_contig", 32'(w), 32'd0);
    expect_idle("err_exit");

    // Timeout: requester 2 never acked
    rqlast = 3'b111;
    rqreq  = 3'b100;
    cyc    = 0;
    @(negedge clk);
    while (!busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("to_own", 32'(busy), 32'd1);
    e.ack = 3'b000;
    e.err = 3'b100;
    e.rd  = 8'h00;
    sb.push_back(e);
    cyc = 1;
    while (rqerr[2] !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("to_cycle", 32'(cyc), 32'd16);
    // hdack during ABORT and IDLE must be ignored
    @(posedge clk); #1;
    hd.hdack = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hdreq", 32'(hd.hdreq), 32'd0);
    check("abort_hdlast", 32'(hd.hdlast), 32'd1);
    @(negedge clk);
    check("post_abort_busy", 32'(busy), 32'd0);
    hd.hdack = 1'b0;
    ack_access(2'd2, 8'h12, 8'h33, 1'b0, 1'b0, 8'h77, 3'b100, w);
    check("abort_len", 32'(w), 32'd0);
    expect_idle("to_done");

    // Asynchronous reset in the middle of an ownership
    rqaddr   = {8'h12, 8'h42, 8'h10};
    rqwrdata = {8'h33, 8'h22, 8'h11};
    rqreq    = 3'b010;
    cyc      = 0;
    @(negedge clk);
    while (!busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("ar_own", 32'(hd.hdreq), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("ar_hdreq", 32'(hd.hdreq), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_grant", 32'(grant), 32'd0);
    rqreq = 3'b111;
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check("ar_first_busy", 32'(busy), 32'd1);
    check("ar_first_grant", 32'(grant), 32'd0);
    ack_access(2'd0, 8'h10, 8'h11, 1'b0, 1'b0, 8'h88, 3'b111, w);
    expect_idle("ar_done");

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hdbus_arb.md
HDBUS_ARB -- requirements
Module: hdbus_arb

Interface
REQ-001 Parameter TIMEOUT, default 4096: hdclk-independent clk cycles an owner may wait for hdack before abort.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 rqaddr  in  24  register address per requester, requester i in bits [8i+7:8i].
REQ-005 rqwrdata  in  24  write data per requester, same packing.
REQ-006 rqreq  in  3  per-requester access request, level, held until rqack/rqerr.
REQ-007 rqwr  in  3  per-requester write (1) / read (0).
REQ-008 rqlast  in  3  per-requester: current access ends the locked sequence.
REQ-009 rqack  out  3  per-requester access-done pulse.
REQ-010 rqerr  out  3  per-requester error pulse (bus error or timeout).
REQ-011 rqrddata  out  8  read data, shared, valid with rqack.
REQ-012 hdaddr, hdwrdata  out  8 each  register-bus address and write data.
REQ-013 hdreq, hdwr, hdlast  out  1 each  register-bus request, write, last.
REQ-014 hdrddata  in  8; hdack  in  1; hderr  in  1  register-bus response.
REQ-015 grant  out  2  current owner index (0-2), meaningful only when busy.
REQ-016 busy  out  1  high in OWN state.

Function
REQ-017 States IDLE, OWN, ABORT; state, grant, rr pointer, timeout counter registered.
REQ-018 IDLE: hdreq=0, hdwr=0, hdlast=1, hdaddr=0, hdwrdata=0, rqack=0, rqerr=0.
REQ-019 IDLE with any rqreq set: pick first set requester scanning pointer+1, pointer+2, pointer (mod 3); next cycle state=OWN, grant=pick.
REQ-020 Arbitration latency exactly 1 cycle: rqreq seen at edge N -> hdreq high after edge N+1.
REQ-021 OWN: hdaddr, hdwrdata, hdwr, hdlast combinationally = owner's rqaddr/rqwrdata/rqwr/rqlast; hdreq = rqreq[grant].
REQ-022 OWN: rqack[grant]=hdack&~hderr, rqerr[grant]=hdack&hderr, same cycle; other requesters' rqack/rqerr stay 0.
REQ-023 rqrddata = hdrddata at all times.
REQ-024 OWN, hdack with rqlast[grant]=1 or hderr=1: next state IDLE, pointer=grant.
REQ-025 OWN, hdack with rqlast[grant]=0 and no hderr: stay OWN (locked sequence, no other requester granted).
REQ-026 OWN, rqreq[grant]=0 and no hdack: next state IDLE, pointer=grant (abandoned sequence).
REQ-027 Timeout counter cleared on entry to OWN and on every hdack; increments each OWN cycle otherwise.
REQ-028 Counter reaching TIMEOUT-1 without hdack: rqerr[grant] pulses 1 cycle, next state ABORT.
REQ-029 ABORT: outputs as IDLE, lasts exactly 1 cycle, then IDLE, pointer=grant.
REQ-030 Every OWN exit passes through IDLE for >=1 cycle; hdreq therefore low >=1 cycle between owners.
REQ-031 hdack/hderr in IDLE or ABORT ignored, no rqack/rqerr generated.
REQ-032 Counter width ceil(log2(TIMEOUT))+1 bits, no wrap before timeout.

Reset
REQ-033 rstn low: immediately state=IDLE, grant=0, pointer=2 (requester 0 first), counter=0; all outputs per REQ-018, busy=0.
REQ-034 Reset mid-OWN drops hdreq asynchronously; no rqack/rqerr emitted for the cut access.
REQ-035 First arbitration after rstn release proceeds normally on the first rising edge.

Verification
REQ-036 rqreq=3'b111 after reset -> grants in order 0,1,2,0, each single access with rqlast=1, one IDLE cycle between.
REQ-037 Req1 addr 8'h42 read, hdack with hdrddata=8'h40 -> hdaddr=8'h42, hdwr=0, rqack=3'b010, rqrddata=8'h40, busy falls next cycle.
REQ-038 Req0 12-write sequence rqlast=0 until 12th while rqreq[2]=1 -> grant stays 0 for all 12 acks, then grant=2.
REQ-039 TIMEOUT=16, owner never acked -> rqerr[grant] pulse on 16th OWN cycle, 1 ABORT cycle, IDLE.
REQ-040 hdack with hderr=1 mid-sequence -> rqerr pulse, rqack=0, return to IDLE despite rqlast=0.
REQ-041 rstn low during OWN with hdreq=1 -> hdreq=0, busy=0 without clock edge; after release requester 0 wins tie.
